// File: rtl/scr1_ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings and the responder FSM state type.
package scr1_ahb_sram_slave_pkg;

  localparam int SCR1_AHB_WIDTH = 32;

  localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] SCR1_HSIZE_8B  = 3'b000;
  localparam logic [2:0] SCR1_HSIZE_16B = 3'b001;
  localparam logic [2:0] SCR1_HSIZE_32B = 3'b010;

  localparam logic SCR1_HRESP_OKAY = 1'b0;
  localparam logic SCR1_HRESP_ERR  = 1'b1;

  typedef enum logic [2:0] {
    SLV_IDLE,
    SLV_WAIT,
    SLV_DATA,
    SLV_ERR1,
    SLV_ERR2
  } scr1_ahb_slv_state_e;

  // Little-endian byte lanes touched by a legal (aligned) transfer.
  function automatic logic [3:0] scr1_ahb_be(logic [2:0] size, logic [1:0] a);
    case (size)
      SCR1_HSIZE_8B:  return 4'b0001 << a;
      SCR1_HSIZE_16B: return a[1] ? 4'b1100 : 4'b0011;
      default:        return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/scr1_ahb_sram_bram.sv
// Byte-enabled single-port word array with combinational read; one byte array per lane.
module scr1_ahb_sram_bram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 2**AW;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we && be[g]) mem[waddr] <= wdata[8*g +: 8];
    end

    assign rdata[8*g +: 8] = mem[raddr];
  end

endmodule

// File: rtl/scr1_ahb_sram_slave.sv
// AHB-Lite SRAM responder: programmable wait states, two-cycle ERROR, saturating error count.
module scr1_ahb_sram_slave
  import scr1_ahb_sram_slave_pkg::*;
#(
  parameter int          MEM_AW    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          AHB_WIDTH = SCR1_AHB_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           wait_cfg,
  input  logic [2:0]           hsize,
  input  logic [1:0]           htrans,
  input  logic [AHB_WIDTH-1:0] haddr,
  input  logic                 hwrite,
  input  logic [AHB_WIDTH-1:0] hwdata,
  output logic                 hready,
  output logic [AHB_WIDTH-1:0] hrdata,
  output logic                 hresp,
  output logic [15:0]          err_cnt
);

  scr1_ahb_slv_state_e state, state_nxt;

  logic [MEM_AW-1:0] addr_q;
  logic [2:0]        size_q;
  logic              wr_q;
  logic [3:0]        wcnt;

  logic        accept, acc_err, mem_we;
  logic [31:0] mem_rdata;

  assign accept  = (htrans == SCR1_HTRANS_NONSEQ || htrans == SCR1_HTRANS_SEQ) && hready;
  assign acc_err = (haddr[31:MEM_AW] != BASE_ADDR[31:MEM_AW])
                 || (hsize > SCR1_HSIZE_32B)
                 || (hsize == SCR1_HSIZE_16B && haddr[0])
                 || (hsize == SCR1_HSIZE_32B && haddr[1:0] != 2'b00);

  // hready depends only on state, so accept never loops back through the next-state logic.
  always_comb begin
    state_nxt = state;
    hready    = 1'b1;
    hresp     = SCR1_HRESP_OKAY;
    case (state)
      SLV_WAIT: hready = 1'b0;
      SLV_ERR1: begin hready = 1'b0; hresp = SCR1_HRESP_ERR; end
      SLV_ERR2: hresp = SCR1_HRESP_ERR;
      default: ;
    endcase
    if (hready) begin
      if (!accept)              state_nxt = SLV_IDLE;
      else if (acc_err)         state_nxt = SLV_ERR1;
      else if (wait_cfg == '0)  state_nxt = SLV_DATA;
      else                      state_nxt = SLV_WAIT;
    end else if (state == SLV_ERR1) begin
      state_nxt = SLV_ERR2;
    end else if (wcnt == 4'd1) begin
      state_nxt = SLV_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SLV_IDLE;
      err_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= haddr[MEM_AW-1:0];
        size_q <= hsize;
        wr_q   <= hwrite;
        wcnt   <= wait_cfg;
      end else if (state == SLV_WAIT) begin
        wcnt <= wcnt - 4'd1;
      end
      if (state == SLV_ERR2 && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

  // A data phase cut short by reset must not reach storage.
  assign mem_we = (state == SLV_DATA) && wr_q && !rst;

  scr1_ahb_sram_bram #(.AW(MEM_AW-2)) u_bram (
    .clk   (clk),
    .we    (mem_we),
    .be    (scr1_ahb_be(size_q, addr_q[1:0])),
    .waddr (addr_q[MEM_AW-1:2]),
    .wdata (hwdata),
    .raddr (addr_q[MEM_AW-1:2]),
    .rdata (mem_rdata)
  );

  assign hrdata = (state == SLV_DATA && !wr_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_scr1_ahb_sram_slave.sv
// Randomized AHB traffic against a byte-level memory model of the SRAM responder.
module tb_scr1_ahb_sram_slave;
  import scr1_ahb_sram_slave_pkg::*;

  localparam int MEM_AW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  wait_cfg = '0;
  logic [2:0]  hsize = '0;
  logic [1:0]  htrans = SCR1_HTRANS_IDLE;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = '0;
  logic        hready;
  logic [31:0] hrdata;
  logic        hresp;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  scr1_ahb_sram_slave #(.MEM_AW(MEM_AW), .BASE_ADDR(32'h0), .AHB_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .wait_cfg(wait_cfg), .hsize(hsize), .htrans(htrans),
    .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hready(hready),
    .hrdata(hrdata), .hresp(hresp), .err_cnt(err_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  ws;
    int          gap;
  } xact_t;

  xact_t      q[$];
  logic [7:0] mem_m [int];
  int         err_m = 0;

  function automatic bit is_err(xact_t t);
    if ((t.addr >> MEM_AW) != 0) return 1;
    if (t.size > 2) return 1;
    return (t.addr % (32'd1 << t.size)) != 0;
  endfunction

  function automatic logic [31:0] rd_word(logic [31:0] a);
    logic [31:0] r;
    int base;
    base = int'(a & 32'h0000_FFFC);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = mem_m.exists(base + i) ? mem_m[base + i] : 8'h00;
    return r;
  endfunction

  function automatic void apply_wr(xact_t t);
    int ba;
    for (int b = 0; b < (1 << t.size); b++) begin
      ba = int'(t.addr & 32'h0000_FFFF) + b;
      mem_m[ba] = t.data[8*(ba % 4) +: 8];
    end
  endfunction

  task automatic push(input bit wr, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] ws, input int gap);
    xact_t t;
    t.wr = wr; t.size = size; t.addr = addr; t.data = data; t.ws = ws; t.gap = gap;
    q.push_back(t);
  endtask

  // Drives the queue as a pipelined AHB master; entered and left at posedge+#1.
  task automatic run_q();
    xact_t       dp;
    bit          dp_v = 0;
    int          dcyc = 0;
    int          guard = 0;
    bit          rdy_e, resp_e;
    logic [31:0] data_e;
    while ((q.size() != 0 || dp_v) && guard < 5000) begin
      guard++;
      rdy_e = 1; resp_e = 0; data_e = '0;
      if (dp_v) begin
        if (is_err(dp)) begin
          rdy_e = (dcyc == 1); resp_e = 1;
        end else begin
          rdy_e = (dcyc >= int'(dp.ws));
          if (rdy_e && !dp.wr) data_e = rd_word(dp.addr);
        end
      end
      if (q.size() != 0 && q[0].gap == 0) begin
        htrans = $urandom_range(1) ? SCR1_HTRANS_NONSEQ : SCR1_HTRANS_SEQ;
        haddr  = q[0].addr; hsize = q[0].size; hwrite = q[0].wr;
      end else begin
        htrans = $urandom_range(1) ? SCR1_HTRANS_IDLE : SCR1_HTRANS_BUSY;
        haddr  = $urandom; hsize = 3'($urandom); hwrite = 1'($urandom);
      end
      wait_cfg = (q.size() != 0 && rdy_e) ? q[0].ws : 4'($urandom);
      hwdata   = (dp_v && dp.wr) ? dp.data : $urandom;
      @(negedge clk);
      chk("hready",  {31'b0, hready}, {31'b0, rdy_e});
      chk("hresp",   {31'b0, hresp},  {31'b0, resp_e});
      chk("hrdata",  hrdata, data_e);
      chk("err_cnt", {16'b0, err_cnt}, err_m);
      if (dp_v) begin
        if (rdy_e) begin
          if (is_err(dp)) begin
            if (err_m < 16'hFFFF) err_m++;
          end else if (dp.wr) begin
            apply_wr(dp);
          end
          dp_v = 0;
        end else begin
          dcyc++;
        end
      end
      if (q.size() != 0 && rdy_e) begin
        if (q[0].gap > 0) q[0].gap--;
        else begin dp = q.pop_front(); dp_v = 1; dcyc = 0; end
      end
      @(posedge clk); #1;
    end
    htrans = SCR1_HTRANS_IDLE;
    if (guard >= 5000) chk("run_q_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    // Reset then idle
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      chk("rst_hready", {31'b0, hready}, 32'd1);
      chk("rst_hresp",  {31'b0, hresp},  32'd0);
      chk("rst_hrdata", hrdata, 32'd0);
      chk("rst_errcnt", {16'b0, err_cnt}, 32'd0);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_hready", {31'b0, hready}, 32'd1);
      chk("idle_hrdata", hrdata, 32'd0);
    end
    @(posedge clk); #1;

    // Back-to-back word write/read, then byte and half lanes
    push(1, SCR1_HSIZE_32B, 32'h100, 32'hDEADBEEF, 0, 0);
    push(0, SCR1_HSIZE_32B, 32'h100, 32'h0, 0, 0);
    push(1, SCR1_HSIZE_32B, 32'h200, 32'h0, 0, 0);
    push(1, SCR1_HSIZE_8B,  32'h201, 32'h0000_AA00, 0, 0);
    push(1, SCR1_HSIZE_16B, 32'h202, 32'h1234_0000, 0, 0);
    push(0, SCR1_HSIZE_32B, 32'h200, 32'h0, 0, 0);
    push(1, SCR1_HSIZE_32B, 32'h300, 32'h11223344, 0, 1);
    run_q();
    chk("lanes_word", rd_word(32'h200), 32'h1234AA00);

    // Three wait states on a read
    push(0, SCR1_HSIZE_32B, 32'h100, 32'h0, 3, 0);
    run_q();

    // Misaligned word and out-of-window write aliasing 0x100
    push(1, SCR1_HSIZE_32B, 32'h102, 32'hFFFFFFFF, 0, 0);
    push(1, SCR1_HSIZE_32B, 32'h10100, 32'h0, 0, 0);
    push(0, SCR1_HSIZE_32B, 32'h100, 32'h0, 0, 0);
    run_q();
    chk("err_cnt_two", {16'b0, err_cnt}, 32'd2);

    // Reset during a wait-stated byte write to 0x300
    htrans = SCR1_HTRANS_NONSEQ; haddr = 32'h300; hsize = SCR1_HSIZE_8B;
    hwrite = 1'b1; wait_cfg = 4'd5;
    @(posedge clk); #1;
    htrans = SCR1_HTRANS_IDLE; hwdata = 32'h0000_0055;
    @(negedge clk);
    chk("rstmid_wait", {31'b0, hready}, 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rstmid_hready", {31'b0, hready}, 32'd1);
    chk("rstmid_errcnt", {16'b0, err_cnt}, 32'd0);
    err_m = 0;
    @(posedge clk); #1;
    push(0, SCR1_HSIZE_32B, 32'h300, 32'h0, 0, 0);
    run_q();

    // Randomized traffic over an initialized region
    for (int i = 0; i < 64; i++) push(1, SCR1_HSIZE_32B, 32'h400 + 4*i, $urandom, 4'($urandom_range(2)), 0);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = 32'h400 + $urandom_range(255);
      if ($urandom_range(7) == 0) a = a | (32'h1 << $urandom_range(31, MEM_AW));
      push(1'($urandom), 3'($urandom_range(3)), a, $urandom,
           4'($urandom_range(3)), ($urandom_range(3) == 0) ? 1 : 0);
    end
    run_q();
    chk("err_cnt_final", {16'b0, err_cnt}, err_m);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
